// File: rtl/midi_pkg.sv
// Parsed MIDI message format shared between the MIDI parser and its consumers.
package MIDI;

    typedef enum logic [2:0] {
        NOTE_OFF       = 3'd0,
        NOTE_ON        = 3'd1,
        CONTROL_CHANGE = 3'd2,
        PROGRAM_CHANGE = 3'd3,
        PITCH_BEND     = 3'd4,
        OTHER          = 3'd7
    } kind_t;

    // data1 = note / controller number, data2 = velocity / controller value
    typedef struct packed {
        kind_t      kind;
        logic [3:0] channel;
        logic [6:0] data1;
        logic [6:0] data2;
    } message_t;

    localparam logic [6:0] DAMPER_PEDAL = 7'd64;

endpackage

// File: rtl/voice_allocator_pkg.sv
// Per-voice state record and scheduler FSM states for the voice allocator.
package VOICE;

    // Wide enough for a rank of up to 16 voices.
    localparam int AGE_BITS = 4;
    localparam logic [AGE_BITS-1:0] AGE_ONE = 4'd1;

    typedef struct packed {
        logic                active;
        logic                gate;
        logic                sustained;
        logic [6:0]          note;
        logic [6:0]          velocity;
        logic [AGE_BITS-1:0] age;
    } voice_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/voice_allocator_select.sv
// Combinational voice search: note matches, lowest free voice and steal candidate.
module voice_select
    import VOICE::*;
#(
    parameter int VOICES = 8
) (
    input  voice_t [VOICES-1:0] voices,
    input  logic   [6:0]        note,
    output logic   [VOICES-1:0] match_active,
    output logic   [VOICES-1:0] match_gated,
    output logic   [VOICES-1:0] free,
    output logic   [VOICES-1:0] steal
);

    logic                found_ma, found_mg, found_fr, found_st, any_released;
    logic [AGE_BITS-1:0] best_age;

    always_comb begin
        match_active = '0;
        match_gated  = '0;
        free         = '0;
        steal        = '0;
        found_ma     = 1'b0;
        found_mg     = 1'b0;
        found_fr     = 1'b0;
        found_st     = 1'b0;
        any_released = 1'b0;
        best_age     = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (voices[i].active && !voices[i].gate) any_released = 1'b1;
            if (!found_ma && voices[i].active && voices[i].note == note) begin
                match_active[i] = 1'b1;
                found_ma        = 1'b1;
            end
            if (!found_mg && voices[i].active && voices[i].gate && voices[i].note == note) begin
                match_gated[i] = 1'b1;
                found_mg       = 1'b1;
            end
            if (!found_fr && !voices[i].active) begin
                free[i]  = 1'b1;
                found_fr = 1'b1;
            end
        end
        // Releasing voices are preferred victims; strict '>' keeps ties on the lowest index.
        for (int i = 0; i < VOICES; i++) begin
            if ((any_released ? (voices[i].active && !voices[i].gate) : voices[i].active)
                && (!found_st || voices[i].age > best_age)) begin
                steal    = '0;
                steal[i] = 1'b1;
                best_age = voices[i].age;
                found_st = 1'b1;
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps note/pedal messages onto shared synthesis voices.
module voice_allocator
    import VOICE::*;
#(
    parameter int VOICES = 8,
    parameter int AGE_W  = $clog2(VOICES)
) (
    input  logic                  clock_50_000_000,
    input  logic                  reset_l,
    input  MIDI::message_t        message,
    input  logic                  message_valid,
    output logic                  message_ready,
    input  logic [VOICES-1:0]     voice_done,
    output logic [VOICES-1:0]     voice_active,
    output logic [VOICES-1:0]     voice_gate,
    output logic [VOICES-1:0]     voice_trigger,
    output logic [VOICES*7-1:0]   voice_note,
    output logic [VOICES*7-1:0]   voice_velocity
);

    state_t              state;
    MIDI::message_t      msg_q;
    logic                pedal;
    voice_t [VOICES-1:0] voices;
    logic [VOICES-1:0]   sel_match_active, sel_match_gated, sel_free, sel_steal;
    logic [VOICES-1:0]   match_on_q, match_off_q, free_q, steal_q;
    logic [VOICES-1:0]   target;
    logic [AGE_W:0]      old_age;
    logic                is_on, is_off, is_cc64;

    voice_select #(.VOICES(VOICES)) u_select (
        .voices       (voices),
        .note         (msg_q.data1),
        .match_active (sel_match_active),
        .match_gated  (sel_match_gated),
        .free         (sel_free),
        .steal        (sel_steal)
    );

    always_comb begin
        is_on   = (msg_q.kind == MIDI::NOTE_ON) && (msg_q.data2 != 7'd0);
        is_off  = (msg_q.kind == MIDI::NOTE_OFF) ||
                  ((msg_q.kind == MIDI::NOTE_ON) && (msg_q.data2 == 7'd0));
        is_cc64 = (msg_q.kind == MIDI::CONTROL_CHANGE) && (msg_q.data1 == MIDI::DAMPER_PEDAL);
        target  = (|match_on_q) ? match_on_q : ((|free_q) ? free_q : steal_q);
        // A fresh (inactive) target sits above every rank, so all active voices age.
        old_age = (AGE_W+1)'(VOICES);
        for (int i = 0; i < VOICES; i++)
            if (target[i] && voices[i].active) old_age = {1'b0, voices[i].age[AGE_W-1:0]};
    end

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            state         <= IDLE;
            msg_q         <= '0;
            pedal         <= 1'b0;
            voices        <= '0;
            voice_trigger <= '0;
            match_on_q    <= '0;
            match_off_q   <= '0;
            free_q        <= '0;
            steal_q       <= '0;
        end else begin
            voice_trigger <= '0;
            for (int i = 0; i < VOICES; i++)
                if (voice_done[i] && voices[i].active && !voices[i].gate)
                    voices[i].active <= 1'b0;
            case (state)
                IDLE: begin
                    if (message_valid) begin
                        msg_q <= message;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    match_on_q  <= sel_match_active;
                    match_off_q <= sel_match_gated;
                    free_q      <= sel_free;
                    steal_q     <= sel_steal;
                    state       <= COMMIT;
                end
                COMMIT: begin
                    state <= IDLE;
                    if (is_on) begin
                        for (int i = 0; i < VOICES; i++) begin
                            if (target[i]) begin
                                voices[i].active    <= 1'b1;
                                voices[i].gate      <= 1'b1;
                                voices[i].sustained <= 1'b0;
                                voices[i].note      <= msg_q.data1;
                                voices[i].velocity  <= msg_q.data2;
                                voices[i].age       <= '0;
                                voice_trigger[i]    <= 1'b1;
                            end else if (voices[i].active &&
                                         {1'b0, voices[i].age[AGE_W-1:0]} < old_age) begin
                                voices[i].age <= voices[i].age + AGE_ONE;
                            end
                        end
                    end else if (is_off) begin
                        for (int i = 0; i < VOICES; i++)
                            if (match_off_q[i]) begin
                                if (pedal) voices[i].sustained <= 1'b1;
                                else       voices[i].gate      <= 1'b0;
                            end
                    end else if (is_cc64) begin
                        pedal <= msg_q.data2[6];
                        if (!msg_q.data2[6])
                            for (int i = 0; i < VOICES; i++)
                                if (voices[i].sustained) begin
                                    voices[i].gate      <= 1'b0;
                                    voices[i].sustained <= 1'b0;
                                end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign message_ready = (state == IDLE);

    always_comb begin
        for (int i = 0; i < VOICES; i++) begin
            voice_active[i]           = voices[i].active;
            voice_gate[i]             = voices[i].gate;
            voice_note[i*7 +: 7]      = voices[i].note;
            voice_velocity[i*7 +: 7]  = voices[i].velocity;
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed scoreboard bench for voice_allocator: stimulus pushes expectations, a monitor checks each commit.
module tb_voice_allocator;

    logic           clock_50_000_000 = 1'b0;
    logic           reset_l = 1'b0;
    MIDI::message_t message = '0;
    logic           message_valid = 1'b0;
    logic           message_ready;
    logic [7:0]     voice_done = '0;
    logic [7:0]     voice_active, voice_gate, voice_trigger;
    logic [55:0]    voice_note, voice_velocity;

    voice_allocator #(.VOICES(8)) dut (
        .clock_50_000_000 (clock_50_000_000),
        .reset_l          (reset_l),
        .message          (message),
        .message_valid    (message_valid),
        .message_ready    (message_ready),
        .voice_done       (voice_done),
        .voice_active     (voice_active),
        .voice_gate       (voice_gate),
        .voice_trigger    (voice_trigger),
        .voice_note       (voice_note),
        .voice_velocity   (voice_velocity)
    );

    always #10 clock_50_000_000 = ~clock_50_000_000;

    typedef struct {
        string       tag;
        logic [7:0]  active;
        logic [7:0]  gate;
        logic [7:0]  trig;
        bit          chk_notes;
        logic [55:0] notes;
        int          vidx;
        logic [6:0]  vel;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic ready_d = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [55:0] mk_notes(input int n7, n6, n5, n4, n3, n2, n1, n0);
        return {7'(n7), 7'(n6), 7'(n5), 7'(n4), 7'(n3), 7'(n2), 7'(n1), 7'(n0)};
    endfunction

    // Commit completion shows as message_ready returning high.
    always @(negedge clock_50_000_000) begin
        if (!reset_l) begin
            ready_d <= 1'b1;
        end else begin
            if (message_ready && !ready_d) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_commit", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk({e.tag, ".active"}, 64'(voice_active), 64'(e.active));
                    chk({e.tag, ".gate"},   64'(voice_gate),   64'(e.gate));
                    chk({e.tag, ".trig"},   64'(voice_trigger), 64'(e.trig));
                    if (e.chk_notes) begin
                        chk({e.tag, ".notes"}, 64'(voice_note), 64'(e.notes));
                        chk({e.tag, ".vel"}, 64'(voice_velocity[e.vidx*7 +: 7]), 64'(e.vel));
                    end
                end
            end else if (voice_trigger != 8'h00) begin
                chk("trigger_outside_commit", 64'(voice_trigger), 64'd0);
            end
            ready_d <= message_ready;
        end
    end

    task automatic send(input MIDI::kind_t kind, input int d1, input int d2);
        int n;
        n = 0;
        @(negedge clock_50_000_000);
        while (!message_ready && n < 20) begin
            @(negedge clock_50_000_000);
            n++;
        end
        if (!message_ready) chk("ready_timeout", 64'd0, 64'd1);
        message.kind    = kind;
        message.channel = 4'd5;
        message.data1   = 7'(d1);
        message.data2   = 7'(d2);
        message_valid   = 1'b1;
        @(posedge clock_50_000_000);
        #1 message_valid = 1'b0;
    endtask

    task automatic expect_msg(input string tag, input logic [7:0] a, input logic [7:0] g,
                              input logic [7:0] t);
        exp_t e;
        e.tag = tag; e.active = a; e.gate = g; e.trig = t;
        e.chk_notes = 1'b0; e.notes = '0; e.vidx = 0; e.vel = '0;
        exp_q.push_back(e);
    endtask

    task automatic expect_full(input string tag, input logic [7:0] a, input logic [7:0] g,
                               input logic [7:0] t, input logic [55:0] notes,
                               input int vidx, input int vel);
        exp_t e;
        e.tag = tag; e.active = a; e.gate = g; e.trig = t;
        e.chk_notes = 1'b1; e.notes = notes; e.vidx = vidx; e.vel = 7'(vel);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clock_50_000_000);
        reset_l = 1'b0;
        repeat (2) @(negedge clock_50_000_000);
        reset_l = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !message_ready) && n < 50) begin
            @(negedge clock_50_000_000);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(negedge clock_50_000_000);
    endtask

    task automatic pulse_done(input logic [7:0] d);
        @(posedge clock_50_000_000);
        #1 voice_done = d;
        @(posedge clock_50_000_000);
        #1 voice_done = '0;
    endtask

    task automatic fill_60_67();
        for (int k = 0; k < 8; k++) begin
            expect_msg($sformatf("fill%0d", k), 8'((1 << (k + 1)) - 1),
                       8'((1 << (k + 1)) - 1), 8'(1 << k));
            send(MIDI::NOTE_ON, 60 + k, 100);
        end
    endtask

    initial begin
        // 1: reset state and a single note
        do_reset();
        @(negedge clock_50_000_000);
        chk("reset.ready",  64'(message_ready), 64'd1);
        chk("reset.active", 64'(voice_active), 64'd0);
        chk("reset.gate",   64'(voice_gate), 64'd0);
        chk("reset.notes",  64'(voice_note), 64'd0);
        chk("reset.trig",   64'(voice_trigger), 64'd0);
        expect_full("t1.on60", 8'h01, 8'h01, 8'h01, mk_notes(0,0,0,0,0,0,0,60), 0, 100);
        send(MIDI::NOTE_ON, 60, 100);
        expect_msg("t1.cc7", 8'h01, 8'h01, 8'h00);
        send(MIDI::CONTROL_CHANGE, 7, 100);
        expect_msg("t1.bend", 8'h01, 8'h01, 8'h00);
        send(MIDI::PITCH_BEND, 60, 0);
        drain();
        pulse_done(8'h01);
        @(negedge clock_50_000_000);
        chk("t1.done_ignored_gated", 64'(voice_active), 64'h01);

        // 2: all voices busy, oldest gated voice is stolen
        do_reset();
        fill_60_67();
        expect_full("t2.steal", 8'hFF, 8'hFF, 8'h01,
                    mk_notes(67,66,65,64,63,62,61,70), 0, 100);
        send(MIDI::NOTE_ON, 70, 100);
        drain();

        // 3: a releasing voice is preferred over the oldest gated one
        do_reset();
        fill_60_67();
        expect_msg("t3.off63", 8'hFF, 8'hF7, 8'h00);
        send(MIDI::NOTE_OFF, 63, 0);
        expect_full("t3.steal_rel", 8'hFF, 8'hFF, 8'h08,
                    mk_notes(67,66,65,64,70,62,61,60), 3, 80);
        send(MIDI::NOTE_ON, 70, 80);
        drain();

        // 4: damper pedal hold, release and envelope done
        do_reset();
        expect_msg("t4.cc64_127", 8'h00, 8'h00, 8'h00);
        send(MIDI::CONTROL_CHANGE, 64, 127);
        expect_msg("t4.on60", 8'h01, 8'h01, 8'h01);
        send(MIDI::NOTE_ON, 60, 100);
        expect_msg("t4.off60_held", 8'h01, 8'h01, 8'h00);
        send(MIDI::NOTE_OFF, 60, 0);
        expect_msg("t4.cc64_0", 8'h01, 8'h00, 8'h00);
        send(MIDI::CONTROL_CHANGE, 64, 0);
        drain();
        pulse_done(8'h01);
        @(negedge clock_50_000_000);
        chk("t4.done_clears", 64'(voice_active), 64'h00);
        expect_msg("t4.cc64_64", 8'h00, 8'h00, 8'h00);
        send(MIDI::CONTROL_CHANGE, 64, 64);
        expect_full("t4.on62", 8'h01, 8'h01, 8'h01, mk_notes(0,0,0,0,0,0,0,62), 0, 90);
        send(MIDI::NOTE_ON, 62, 90);
        expect_msg("t4.off62_held", 8'h01, 8'h01, 8'h00);
        send(MIDI::NOTE_OFF, 62, 0);
        expect_msg("t4.cc64_63", 8'h01, 8'h00, 8'h00);
        send(MIDI::CONTROL_CHANGE, 64, 63);
        drain();

        // 5: velocity-0 note-off, then retrigger of the releasing voice
        do_reset();
        expect_msg("t5.on60", 8'h01, 8'h01, 8'h01);
        send(MIDI::NOTE_ON, 60, 90);
        expect_msg("t5.on60_v0", 8'h01, 8'h00, 8'h00);
        send(MIDI::NOTE_ON, 60, 0);
        expect_full("t5.retrig", 8'h01, 8'h01, 8'h01, mk_notes(0,0,0,0,0,0,0,60), 0, 50);
        send(MIDI::NOTE_ON, 60, 50);
        drain();

        // 6: reset during COMMIT abandons the message
        do_reset();
        expect_msg("t6.on60", 8'h01, 8'h01, 8'h01);
        send(MIDI::NOTE_ON, 60, 100);
        drain();
        send(MIDI::NOTE_ON, 62, 100);
        @(posedge clock_50_000_000);
        #2 reset_l = 1'b0;
        #1;
        chk("t6.rst_active", 64'(voice_active), 64'd0);
        chk("t6.rst_gate",   64'(voice_gate), 64'd0);
        chk("t6.rst_trig",   64'(voice_trigger), 64'd0);
        chk("t6.rst_notes",  64'(voice_note), 64'd0);
        chk("t6.rst_ready",  64'(message_ready), 64'd1);
        repeat (2) @(negedge clock_50_000_000);
        reset_l = 1'b1;
        expect_full("t6.on61", 8'h01, 8'h01, 8'h01, mk_notes(0,0,0,0,0,0,0,61), 0, 70);
        send(MIDI::NOTE_ON, 61, 70);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
